// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM.
// Supports locked bursts and returns read data with per-port valid strobes.
module ram_port_arbiter #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_SIZE  = 24,
  localparam int AW = $clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic                 lock0,
  input  logic                 lock1,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [MEM_WIDTH-1:0] di0,
  input  logic [MEM_WIDTH-1:0] di1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [MEM_WIDTH-1:0] rdata,
  output logic                 err0,
  output logic                 err1,
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [AW-1:0]        ram_addr,
  output logic [MEM_WIDTH-1:0] ram_di,
  input  logic [MEM_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  localparam logic [AW:0] LIMIT = (AW+1)'(MEM_SIZE);

  state_t state;
  logic   rr_ptr;
  logic   oor0;
  logic   oor1;
  logic   sel_oor;

  assign oor0  = {1'b0, addr0} >= LIMIT;
  assign oor1  = {1'b0, addr1} >= LIMIT;
  assign rdata = ram_dout;

  // Grants are masked during reset so nothing reaches the RAM.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (req0 && req1) begin
            gnt0 = ~rr_ptr;
            gnt1 = rr_ptr;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        LOCK0:   gnt0 = req0;
        LOCK1:   gnt1 = req1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_di   = '0;
    sel_oor  = 1'b0;
    if (gnt0) begin
      ram_we   = we0;
      ram_addr = addr0;
      ram_di   = di0;
      sel_oor  = oor0;
    end else if (gnt1) begin
      ram_we   = we1;
      ram_addr = addr1;
      ram_di   = di1;
      sel_oor  = oor1;
    end
  end

  assign ram_en = (gnt0 | gnt1) & ~sel_oor;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rr_ptr  <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~we0 & ~oor0;
      rvalid1 <= gnt1 & ~we1 & ~oor1;
      err0    <= gnt0 & oor0;
      err1    <= gnt1 & oor1;
      unique case (state)
        IDLE: begin
          if (gnt0) begin
            rr_ptr <= 1'b1;
            if (lock0) state <= LOCK0;
          end else if (gnt1) begin
            rr_ptr <= 1'b0;
            if (lock1) state <= LOCK1;
          end
        end
        LOCK0: if (!lock0) state <= IDLE;
        LOCK1: if (!lock1) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed and random checks for ram_port_arbiter.
// Includes a behavioural 1-cycle write-first BRAM.
module tb_ram_port_arbiter;

  localparam int MW = 32;
  localparam int MS = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic          we0 = 1'b0, we1 = 1'b0;
  logic          lock0 = 1'b0, lock1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [MW-1:0] di0 = '0, di1 = '0;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [MW-1:0] rdata;
  logic          err0, err1;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [MW-1:0] ram_di;
  logic [MW-1:0] ram_dout;

  int checks = 0;
  int errors = 0;

  logic [MW-1:0] mem [0:31];

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_di;
      ram_dout <= ram_we ? ram_di : mem[ram_addr];
    end
  end

  ram_port_arbiter #(.MEM_WIDTH(MW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .di0(di0), .di1(di1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata),
    .err0(err0), .err1(err1),
    .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_dout(ram_dout)
  );

  task automatic clear_inputs;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    lock0 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; di0 = '0; di1 = '0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req0 = 1; req1 = 1;
    #1;
    checks++;
    if ({gnt0, gnt1, ram_en} !== 3'b000) begin
      errors++;
      $display("FAIL reset_gnt: got %b want 000", {gnt0, gnt1, ram_en});
    end
    checks++;
    if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_regs: got %b want 0000",
               {rvalid0, rvalid1, err0, err1});
    end
    do_reset();
  endtask

  task automatic test_write_read;
    req0 = 1; we0 = 1; addr0 = 5; di0 = 32'hDEADBEEF;
    #1;
    checks++;
    if ({gnt0, gnt1, ram_en, ram_we} !== 4'b1011 ||
        ram_addr !== 5'd5 || ram_di !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_drive: got g%b%b en%b we%b a%0d d%h",
               gnt0, gnt1, ram_en, ram_we, ram_addr, ram_di);
    end
    @(negedge clk);
    we0 = 0;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || ram_we !== 1'b0 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL rd_grant: got g%b we%b rv%b want 1 0 0",
               gnt0, ram_we, rvalid0);
    end
    @(negedge clk);
    req0 = 0;
    #1;
    checks++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 ||
        rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_data: got rv%b%b %h want 10 deadbeef",
               rvalid0, rvalid1, rdata);
    end
    checks++;
    if (ram_en !== 1'b0 || ram_addr !== '0 || ram_di !== '0) begin
      errors++;
      $display("FAIL idle_drive: got en%b a%0d d%h want 0 0 0",
               ram_en, ram_addr, ram_di);
    end
  endtask

  task automatic test_round_robin;
    logic [MW-1:0] exp_d;
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 1; di0 = 32'h11111111;
    @(negedge clk);
    req0 = 0;
    req1 = 1; we1 = 1; addr1 = 2; di1 = 32'h22222222;
    @(negedge clk);
    do_reset();
    req0 = 1; we0 = 0; addr0 = 1;
    req1 = 1; we1 = 0; addr1 = 2;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        req0 = 0; req1 = 0;
      end
      #1;
      if (i > 0) begin
        exp_d = (i % 2 == 1) ? 32'h11111111 : 32'h22222222;
        checks++;
        if (rvalid0 !== (i % 2 == 1) || rvalid1 !== (i % 2 == 0) ||
            rdata !== exp_d) begin
          errors++;
          $display("FAIL rr_rvalid[%0d]: got %b%b %h want %b%b %h",
                   i, rvalid0, rvalid1, rdata,
                   (i % 2 == 1), (i % 2 == 0), exp_d);
        end
      end
      if (i < 4) begin
        checks++;
        if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL rr_gnt[%0d]: got %b%b want %b%b",
                   i, gnt0, gnt1, (i % 2 == 0), (i % 2 == 1));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lock_burst;
    logic [4:0] g0;
    logic [4:0] g1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      req1  = (i < 3);
      we1   = 1;
      lock1 = (i < 4);
      addr1 = AW'(10 + (i < 3 ? i : 2));
      di1   = 32'hB0000000 + i;
      if (i == 1) begin
        req0 = 1; we0 = 0; addr0 = 5;
      end
      #1;
      checks++;
      if (gnt0 !== (i == 5) || gnt1 !== (i < 3)) begin
        errors++;
        $display("FAIL lock_gnt[%0d]: got %b%b want %b%b",
                 i, gnt0, gnt1, (i == 5), (i < 3));
      end
      @(negedge clk);
      if (i == 5) req0 = 0;
    end
    #1;
    checks++;
    if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lock_wait_rd: got %b %h want 1 deadbeef",
               rvalid0, rdata);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req1 = (i < 3); we1 = 0; lock1 = 0;
      addr1 = AW'(10 + (i < 3 ? i : 0));
      #1;
      if (i > 0) begin
        checks++;
        if (rvalid1 !== 1'b1 || rdata !== 32'hB0000000 + (i - 1)) begin
          errors++;
          $display("FAIL burst_rd[%0d]: got %b %h want 1 %h",
                   i, rvalid1, rdata, 32'hB0000000 + (i - 1));
        end
      end
      @(negedge clk);
    end
    g0 = '0; g1 = '0;
  endtask

  task automatic test_out_of_range;
    req1 = 1; we1 = 0; addr1 = 24;
    #1;
    checks++;
    if (gnt1 !== 1'b1 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL oor_gnt: got g%b en%b want 1 0", gnt1, ram_en);
    end
    @(negedge clk);
    req1 = 0;
    #1;
    checks++;
    if (err1 !== 1'b1 || rvalid1 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL oor_err: got e%b rv%b e0%b want 1 0 0",
               err1, rvalid1, err0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (err1 !== 1'b0 || rvalid1 !== 1'b0) begin
      errors++;
      $display("FAIL oor_pulse: got e%b rv%b want 0 0", err1, rvalid1);
    end
  endtask

  task automatic test_reset_mid_read;
    int seen;
    @(negedge clk);
    lock1 = 0;
    req1 = 1; we1 = 0; addr1 = 3;
    @(negedge clk);
    req1 = 0;
    req0 = 1; we0 = 0; addr0 = 5;
    #1;
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL mid_gnt: got %b want 1", gnt0);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt0, gnt1, ram_en, rvalid0, rvalid1, err0, err1} !== 7'd0) begin
      errors++;
      $display("FAIL mid_rst_out: got %b want 0000000",
               {gnt0, gnt1, ram_en, rvalid0, rvalid1, err0, err1});
    end
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #2;
      if (rvalid0 !== 1'b0 || ram_en !== 1'b0) seen++;
    end
    @(negedge clk);
    checks++;
    if (seen != 0 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_rvalid: got %0d hits rv%b want 0 0",
               seen, rvalid0);
    end
    rst = 1'b0;
    req0 = 1; we0 = 0; addr0 = 5;
    req1 = 1; we1 = 0; addr1 = 5;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_rr: got %b%b want 10", gnt0, gnt1);
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    #1;
    checks++;
    if (rvalid0 !== 1'b1 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_rst_rd: got %b %h want 1 deadbeef",
               rvalid0, rdata);
    end
  endtask

  task automatic test_random;
    logic [MW-1:0] refm [0:MS-1];
    int st;
    bit rr, eg0, eg1, pend0, pend1;
    bit erv0, erv1, eer0, eer1;
    logic [MW-1:0] ed;
    int w0, w1, bad;
    do_reset();
    for (int i = 0; i < MS; i++) begin
      req0 = 1; we0 = 1; addr0 = AW'(i); di0 = 32'hA5000000 ^ (i * 977);
      refm[i] = di0;
      @(negedge clk);
    end
    do_reset();
    st = 0; rr = 0; pend0 = 0; pend1 = 0;
    erv0 = 0; erv1 = 0; eer0 = 0; eer1 = 0; ed = '0;
    w0 = 0; w1 = 0; bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      checks++;
      if (rvalid0 !== erv0 || rvalid1 !== erv1 ||
          err0 !== eer0 || err1 !== eer1) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got %b%b%b%b want %b%b%b%b", c,
                 rvalid0, rvalid1, err0, err1, erv0, erv1, eer0, eer1);
      end
      if (erv0 || erv1) begin
        checks++;
        if (rdata !== ed) begin
          errors++;
          $display("FAIL rnd_data[%0d]: got %h want %h", c, rdata, ed);
        end
      end
      if (!pend0) begin
        req0  = $urandom_range(0, 1);
        we0   = $urandom_range(0, 1);
        lock0 = ($urandom_range(0, 3) == 0);
        addr0 = ($urandom_range(0, 15) == 0) ?
                AW'($urandom_range(24, 31)) : AW'($urandom_range(0, 23));
        di0   = $urandom;
      end
      if (!pend1) begin
        req1  = $urandom_range(0, 1);
        we1   = $urandom_range(0, 1);
        lock1 = ($urandom_range(0, 3) == 0);
        addr1 = ($urandom_range(0, 15) == 0) ?
                AW'($urandom_range(24, 31)) : AW'($urandom_range(0, 23));
        di1   = $urandom;
      end
      #1;
      eg0 = 0; eg1 = 0;
      if (st == 0) begin
        if (req0 && req1) begin
          eg0 = !rr; eg1 = rr;
        end else begin
          eg0 = req0; eg1 = req1;
        end
      end else if (st == 1) eg0 = req0;
      else eg1 = req1;
      checks++;
      if (gnt0 !== eg0 || gnt1 !== eg1) begin
        errors++;
        $display("FAIL rnd_gnt[%0d]: got %b%b want %b%b",
                 c, gnt0, gnt1, eg0, eg1);
      end
      checks++;
      if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
        errors++;
        $display("FAIL rnd_excl[%0d]: got 11 want at most one", c);
      end
      erv0 = eg0 && !we0 && addr0 < MS;
      erv1 = eg1 && !we1 && addr1 < MS;
      eer0 = eg0 && addr0 >= MS;
      eer1 = eg1 && addr1 >= MS;
      checks++;
      if (ram_en !== ((eg0 && addr0 < MS) || (eg1 && addr1 < MS))) begin
        errors++;
        $display("FAIL rnd_en[%0d]: got %b", c, ram_en);
      end
      if (erv0) ed = refm[addr0];
      if (erv1) ed = refm[addr1];
      if (eg0 && we0 && addr0 < MS) refm[addr0] = di0;
      if (eg1 && we1 && addr1 < MS) refm[addr1] = di1;
      if (st == 0) begin
        if (eg0) begin
          rr = 1; if (lock0) st = 1;
        end else if (eg1) begin
          rr = 0; if (lock1) st = 2;
        end
      end else if (st == 1 && !lock0) st = 0;
      else if (st == 2 && !lock1) st = 0;
      pend0 = req0 && !eg0;
      pend1 = req1 && !eg1;
      w0 = pend0 ? w0 + 1 : 0;
      w1 = pend1 ? w1 + 1 : 0;
      if (w0 > 64 || w1 > 64) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_starve: got %0d long waits want 0", bad);
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_lock_burst();
    test_out_of_range();
    test_reset_mid_read();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one single-port BRAM (the design's 1-cycle-read, write-first block RAM) between two requesters, e.g. the input loader (port 0) and the polynomial arithmetic engine (port 1).
- Provides round-robin arbitration with an optional lock for uninterrupted bursts, and returns read data with a per-requester valid strobe.
- Sits directly in front of the RAM instance. All RAM control signals come from this block.

Parameters:
- MEM_WIDTH, 32, data width of the RAM word.
- MEM_SIZE, 24, number of RAM words. Address width AW = $clog2(MEM_SIZE), derived internally and not overridable.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  access request, held until granted.
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqK.
- lock0 / lock1  in  1  keep ownership after this grant.
- addr0 / addr1  in  AW  word address.
- di0 / di1  in  MEM_WIDTH  write data.
- gnt0 / gnt1  out  1  combinational; request accepted this cycle.
- rvalid0 / rvalid1  out  1  registered; rdata valid for that requester.
- rdata  out  MEM_WIDTH  shared read data, equals ram_dout.
- err0 / err1  out  1  registered; 1-cycle pulse on an out-of-range access.
- ram_en  out  1  to RAM en.
- ram_we  out  1  to RAM we.
- ram_addr  out  AW  to RAM addr.
- ram_di  out  MEM_WIDTH  to RAM di.
- ram_dout  in  MEM_WIDTH  from RAM dout (registered inside the RAM).

Behaviour:
- **Reset** (async, while rst=1):
  - state=IDLE, rr_ptr=0 (port 0 has priority).
  - rvalid0/1=0, err0/1=0.
  - gnt0/1=0 and ram_en=0 regardless of requests.
  - A read issued in the cycle before reset never produces rvalid.
- **States:**
  - IDLE: no owner.
  - LOCK0: port 0 owns the RAM.
  - LOCK1: port 1 owns the RAM.
- **IDLE arbitration:**
  - Only one of reqK high: that port is granted.
  - Both high: port rr_ptr is granted.
  - After any grant to port K, rr_ptr <= ~K.
  - If lockK=1 on the granting cycle: next state is LOCKK.
- **LOCKK:**
  - Only port K can be granted. reqK is granted every cycle it is asserted.
  - The other port waits even if port K is idle that cycle.
  - rr_ptr does not change while locked.
  - Exit to IDLE when lockK=0. This is sampled every cycle, with or without reqK.
  - The cycle with lockK=0 may itself carry a granted access.
  - The other port can be granted from the following cycle.
- **RAM drive:**
  - ram_en = gnt0|gnt1.
  - ram_we/ram_addr/ram_di are muxed combinationally from the granted port.
  - With no grant: ram_we=0, ram_addr=0, ram_di=0.
  - At most one gnt is high per cycle.
- **Read latency:**
  - A granted read in cycle N gives rvalidK=1 in cycle N+1, with rdata = RAM[addr] in that cycle.
  - Back-to-back grants give one word per cycle with no bubbles.
  - A granted write in cycle N does not assert rvalid.
- **Range check:**
  - addrK >= MEM_SIZE while reqK=1: the request is still granted (the handshake completes).
  - ram_en is forced to 0 for that cycle, so the RAM is untouched.
  - errK pulses in N+1; rvalidK stays 0.
- **Other rules:**
  - Requester contract: addr/we/di/lock stay stable while reqK=1 and gntK=0.
  - lockK asserted with reqK=0 in IDLE has no effect.

Test Plan:
1. Reset, then req0 write addr 5 data 0xDEADBEEF; next cycle req0 read addr 5 -> gnt0 in both cycles; rvalid0=1 with rdata=0xDEADBEEF one cycle after the read; rvalid1=0.
2. req0 and req1 both held as reads of addr 1 and addr 2 for 4 cycles from reset -> grants alternate 0,1,0,1; rvalid pattern matches one cycle later with the correct data per port.
3. Port 1 locks for a 3-word write burst at addr 10..12, idles one cycle with lock1 still high while req0 waits, then drops lock1 -> gnt0=0 for the whole burst including the idle cycle; gnt0 the cycle after lock1=0; later reads of 10..12 return the burst data.
4. req1 read addr 24 with MEM_SIZE=24 -> gnt1=1, ram_en=0, err1 pulses for 1 cycle, rvalid1 stays 0.
5. Read granted, then rst asserted before the next clock edge and held 2 cycles -> rvalid0 never rises; all outputs 0 during reset; state IDLE and rr_ptr=0 afterwards (a simultaneous request goes to port 0).
6. 1000 random cycles on both ports with random lock, checked against a reference memory model -> all rdata match; gnt0&gnt1 never both 1; no request starves beyond the end of the other port's lock plus 1 cycle.
